des_round_key_sequencer: RTL
============================

DES_ROUND_KEY_SEQUENCER -- requirements
Module: des_round_key_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 1, giving the number of 64-bit DES keys: 1 = single DES, 2 or 3 = triple-DES EDE keying.
REQ-002 The block SHALL have parameter PARITY_CHECK, default 0; when 1, DES odd-byte-parity checking is enabled.
REQ-003 Clock and reset SHALL be: one clock, `clk`; reset `rst`, synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a key schedule run; accepted only when busy=0.
REQ-007 decrypt  input  1  run direction, sampled at start acceptance.
REQ-008 key_in  input  64*NUM_KEYS  keys; slot s occupies [64*s+63:64*s]; bit 63 of a slot = DES key bit 1.
REQ-009 busy  output  1  high from the cycle after acceptance until the final handshake completes.
REQ-010 rk_valid  output  1  rk_data is a valid round key.
REQ-011 rk_ready  input  1  consumer accepts rk_data; handshake = rk_valid & rk_ready.
REQ-012 rk_data  output  48  current round key, PC-2 output of the C/D register.
REQ-013 rk_round  output  4  DES round number of rk_data minus 1: 0 = K1, 15 = K16.
REQ-014 rk_slot  output  2  key slot producing rk_data.
REQ-015 rk_last  output  1  rk_data is the final key of the run.
REQ-016 done  output  1  one-cycle pulse after the final handshake.
REQ-017 parity_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-018 States SHALL be IDLE and RUN. IDLE->RUN on start&!busy with parity OK. RUN->IDLE on the handshake where rk_last=1.
REQ-019 Shift schedule SHALL be: rounds 1, 2, 9 and 16 shift by 1; all other rounds shift by 2; each 28-bit half rotates independently.
REQ-020 Slot order SHALL be 0..NUM_KEYS-1 when decrypt=0 and NUM_KEYS-1..0 when decrypt=1.
REQ-021 Per-slot direction SHALL be dir = decrypt XOR (position in run is odd): EDE yields E,D,E for encrypt and D,E,D for decrypt.
REQ-022 Forward slot: C/D loaded with rotl1(PC1(key)); rk_round counts 0..15; on each handshake C/D <= rotl(C/D, shift[next round]).
REQ-023 Reverse slot: C/D loaded with PC1(key), which equals C16/D16; rk_round counts 15..0; on each handshake C/D <= rotr(C/D, shift[current round]).
REQ-024 Latency: on the cycle after start acceptance, rk_valid=1 and rk_data = first key.
REQ-025 rk_valid SHALL remain 1 and rk_data/rk_round/rk_slot SHALL stay stable while rk_ready=0; there is no bubble between keys, including across slot boundaries.
REQ-026 At slot end (16th handshake, not last), the next slot's key SHALL be PC-1 loaded in the same edge, and rk_valid SHALL stay 1.
REQ-027 rk_last SHALL be 1 only for the 16th key of the final slot; a run SHALL emit exactly 16*NUM_KEYS keys.
REQ-028 start while busy=1 SHALL be ignored, including in the same cycle as the final handshake. A new start is accepted the cycle done is high.
REQ-029 key_in and decrypt SHALL be registered at acceptance; later changes SHALL not affect the run.
REQ-030 With PARITY_CHECK=1, if any byte of any slot has even parity at start: the block stays IDLE, parity_err pulses the next cycle, and no keys or done are produced. With PARITY_CHECK=0, parity_err SHALL be tied 0.

Reset
REQ-031 When rst=1 on any edge, including mid-run, the block SHALL go to IDLE. busy, rk_valid, rk_last, done and parity_err SHALL be 0. rk_data, rk_round and rk_slot SHALL be 0.
REQ-032 rst SHALL take priority over start and handshakes in the same cycle.

Verification
REQ-033 NUM_KEYS=1, key 133457799BBCDFF1, decrypt=0, rk_ready=1 -> first cycle K1=1B02EFFC7072 with rk_round=0; 16 consecutive keys; 16th = CB3D8B0E17F5 with rk_last=1; done on the next cycle.
REQ-034 Same key, decrypt=1 -> first key CB3D8B0E17F5 with rk_round=15; last key 1B02EFFC7072 with rk_round=0.
REQ-035 rk_ready held 0 for 5 cycles at key 3 -> rk_data/rk_round stable throughout; the total of 16 keys is unchanged.
REQ-036 NUM_KEYS=3, decrypt=0 -> 48 keys: slot 0 forward, slot 1 reverse, slot 2 forward, no gaps. decrypt=1 -> slot 2 reverse, slot 1 forward, slot 0 reverse.
REQ-037 PARITY_CHECK=1, key 133457799BBCDFF0 -> parity_err pulse, busy stays 0, no rk_valid.
REQ-038 rst at key 7, with start held high -> all outputs 0 next cycle. With rst released, a start the following cycle restarts cleanly at K1.

Source files
------------

// File: rtl/des_round_key_sequencer.sv
// DES round-key sequencer.
// Streams the 16 round keys of one or more 64-bit DES keys over a
// valid/ready handshake. Consecutive slots alternate direction for EDE keying.
// C/D is rotated in place, forward (K1..K16) or in reverse (K16..K1).
module des_round_key_sequencer #(
  parameter int NUM_KEYS     = 1,
  parameter int PARITY_CHECK = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     decrypt,
  input  logic [64*NUM_KEYS-1:0]   key_in,
  output logic                     busy,
  output logic                     rk_valid,
  input  logic                     rk_ready,
  output logic [47:0]              rk_data,
  output logic [3:0]               rk_round,
  output logic [1:0]               rk_slot,
  output logic                     rk_last,
  output logic                     done,
  output logic                     parity_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [1:0] LAST_POS = 2'(NUM_KEYS - 1);

  // DES bit numbering: table entry p refers to key bit p, 1 = MSB.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  state_t                  state_q, state_d;
  logic [55:0]             cd_q, cd_d;
  logic [3:0]              round_q, round_d;
  logic [1:0]              pos_q, pos_d;
  logic [1:0]              slot_q, slot_d;
  logic                    dir_q, dir_d;
  logic                    done_q, done_d;
  logic                    perr_q, perr_d;
  logic [56*NUM_KEYS-1:0]  keys_q;
  logic                    dec_q;
  logic                    capture;

  logic [56*NUM_KEYS-1:0]  pc1_in;
  logic                    par_bad, par_fail;
  logic                    slot_end;
  logic [1:0]              next_pos, next_slot, first_slot;
  logic                    next_dir, load_dir;
  logic [55:0]             load_src, load_cd;

  // Rotate each 28-bit half left by 1 or 2 (DES "left shift").
  function automatic logic [55:0] rotl(input logic [55:0] v, input logic two);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (two) begin
      c = {c[25:0], c[27:26]};
      d = {d[25:0], d[27:26]};
    end else begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    return {c, d};
  endfunction

  // Inverse of rotl, used to walk the schedule backwards.
  function automatic logic [55:0] rotr(input logic [55:0] v, input logic two);
    logic [27:0] c, d;
    c = v[55:28];
    d = v[27:0];
    if (two) begin
      c = {c[1:0], c[27:2]};
      d = {d[1:0], d[27:2]};
    end else begin
      c = {c[0], c[27:1]};
      d = {d[0], d[27:1]};
    end
    return {c, d};
  endfunction

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one, the rest by two.
  function automatic logic shift_two(input logic [3:0] r);
    return !(r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15);
  endfunction

  // PC-1 of every incoming slot; parity bits drop out here.
  for (genvar s = 0; s < NUM_KEYS; s++) begin : g_slot
    for (genvar j = 0; j < 56; j++) begin : g_pc1
      assign pc1_in[56*s + 55 - j] = key_in[64*s + 64 - PC1[j]];
    end
  end

  // PC-2 of the live C/D register is the round key.
  for (genvar j = 0; j < 48; j++) begin : g_pc2
    assign rk_data[47 - j] = cd_q[56 - PC2[j]];
  end

  // Any byte of any slot with even parity makes the key set invalid.
  always_comb begin
    par_bad = 1'b0;
    for (int b = 0; b < 8*NUM_KEYS; b++) begin
      if (!(^key_in[8*b +: 8])) par_bad = 1'b1;
    end
  end

  if (PARITY_CHECK != 0) begin : g_par
    assign par_fail = par_bad;
  end else begin : g_nopar
    logic unused_parity;
    assign unused_parity = par_bad;
    assign par_fail      = 1'b0;
  end

  // Slot sequencing and the C/D value loaded at the start of a slot.
  always_comb begin
    slot_end   = dir_q ? (round_q == 4'd0) : (round_q == 4'd15);
    next_pos   = pos_q + 2'd1;
    next_slot  = dec_q ? (LAST_POS - next_pos) : next_pos;
    next_dir   = dec_q ^ next_pos[0];
    first_slot = decrypt ? LAST_POS : 2'd0;
    load_dir   = (state_q == IDLE) ? decrypt : next_dir;
    load_src   = '0;
    for (int s = 0; s < NUM_KEYS; s++) begin
      if (state_q == IDLE) begin
        if (first_slot == 2'(s)) load_src = pc1_in[56*s +: 56];
      end else if (next_slot == 2'(s)) begin
        load_src = keys_q[56*s +: 56];
      end
    end
    // Forward slots start at C1/D1; reverse slots start at C0/D0 == C16/D16.
    load_cd = load_dir ? load_src : rotl(load_src, 1'b0);
  end

  // Next-state logic for the IDLE/RUN controller and the C/D datapath.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    pos_d   = pos_q;
    slot_d  = slot_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (par_fail) begin
            perr_d = 1'b1;
          end else begin
            state_d = RUN;
            capture = 1'b1;
            pos_d   = 2'd0;
            slot_d  = first_slot;
            dir_d   = decrypt;
            cd_d    = load_cd;
            round_d = decrypt ? 4'd15 : 4'd0;
          end
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (slot_end) begin
            if (pos_q == LAST_POS) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              pos_d   = next_pos;
              slot_d  = next_slot;
              dir_d   = next_dir;
              cd_d    = load_cd;
              round_d = next_dir ? 4'd15 : 4'd0;
            end
          end else if (dir_q) begin
            cd_d    = rotr(cd_q, shift_two(round_q));
            round_d = round_q - 4'd1;
          end else begin
            cd_d    = rotl(cd_q, shift_two(round_q + 4'd1));
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and C/D state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cd_q    <= '0;
      round_q <= 4'd0;
      pos_q   <= 2'd0;
      slot_q  <= 2'd0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      pos_q   <= pos_d;
      slot_q  <= slot_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  // Key set and direction captured at acceptance.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are left unreset; they are always written on
    // acceptance before anything reads them.
    if (capture) begin
      keys_q <= pc1_in;
      dec_q  <= decrypt;
    end
  end

  assign busy       = (state_q == RUN);
  assign rk_valid   = (state_q == RUN);
  assign rk_round   = round_q;
  assign rk_slot    = slot_q;
  assign rk_last    = (state_q == RUN) && slot_end && (pos_q == LAST_POS);
  assign done       = done_q;
  assign parity_err = perr_q;

endmodule
